// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame config constants
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF  = 16;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic STOP_ONE    = 1'b0;
  localparam logic STOP_TWO    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable baud down-counter, bit_end while the count is zero
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  output logic             o_bit_end
);

  logic [DIV_W-1:0] r_cnt;

  // Holds at zero when not reloaded, so an idle timer reports bit_end continuously.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_bit_end = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - pops bytes from the TX FIFO read side and serializes UART frames
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              i_rempty,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_rinc,
  input  logic [DIV_W-1:0]  i_baud_div,
  input  logic              i_tx_en,
  input  logic              i_parity_en,
  input  logic              i_parity_odd,
  input  logic              i_two_stop,
  output logic              o_txd,
  output logic              o_tx_busy,
  output logic              o_tx_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic              r_txd;
  logic              w_txd_nxt;

  logic [DIV_W-1:0]  r_div;
  logic              r_par_en;
  logic              r_two_stop;
  logic              r_par_bit;

  logic              w_bit_end;
  logic              w_frame_end;
  logic              w_rinc;
  logic              w_load;
  logic [DIV_W-1:0]  w_load_val;

  // In STOP the bit counter indexes the stop bit, so bit 1 is the final one of two.
  assign w_frame_end = (r_state == ST_STOP) && w_bit_end && (!r_two_stop || r_bit_cnt[0]);

  // Gated by reset so nothing is popped while the engine is held in reset.
  assign w_rinc = rrst_n && i_tx_en && !i_rempty && ((r_state == ST_IDLE) || w_frame_end);

  assign w_load     = w_rinc || (w_bit_end && (r_state != ST_IDLE) && !w_frame_end);
  assign w_load_val = w_rinc ? i_baud_div : r_div;

  uart_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_bit_end  (w_bit_end)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  // Frame configuration is frozen at the pop so mid-frame changes wait for the next byte.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_div      <= '0;
      r_par_en   <= 1'b0;
      r_two_stop <= STOP_ONE;
      r_par_bit  <= 1'b0;
    end else if (w_rinc) begin
      r_div      <= i_baud_div;
      r_par_en   <= i_parity_en;
      r_two_stop <= i_two_stop;
      r_par_bit  <= (^i_rdata) ^ i_parity_odd;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_txd_nxt     = r_txd;
    case (r_state)
      ST_IDLE: begin
        w_txd_nxt = 1'b1;
        if (w_rinc) begin
          w_state_nxt   = ST_START;
          w_shift_nxt   = i_rdata;
          w_bit_cnt_nxt = '0;
          w_txd_nxt     = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = '0;
          w_txd_nxt     = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = r_par_en ? ST_PARITY : ST_STOP;
            w_txd_nxt     = r_par_en ? r_par_bit : 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            w_shift_nxt   = r_shift >> 1;
            w_txd_nxt     = r_shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_STOP;
          w_bit_cnt_nxt = '0;
          w_txd_nxt     = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_frame_end) begin
          w_bit_cnt_nxt = '0;
          if (w_rinc) begin
            w_state_nxt = ST_START;
            w_shift_nxt = i_rdata;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_txd_nxt   = 1'b1;
          end
        end else if (w_bit_end) begin
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_bit_cnt_nxt = '0;
        w_txd_nxt     = 1'b1;
      end
    endcase
  end

  assign o_rinc    = w_rinc;
  assign o_txd     = r_txd;
  assign o_tx_busy = (r_state != ST_IDLE);
  assign o_tx_done = w_frame_end;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - self-checking bench for uart_tx_engine
module tb_uart_tx_engine;

  logic        rclk;
  logic        rrst_n;
  logic        i_rempty;
  logic [7:0]  i_rdata;
  logic        o_rinc;
  logic [15:0] i_baud_div;
  logic        i_tx_en;
  logic        i_parity_en;
  logic        i_parity_odd;
  logic        i_two_stop;
  logic        o_txd;
  logic        o_tx_busy;
  logic        o_tx_done;

  int checks;
  int failures;
  int pop_count;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       odd;
    logic       two;
    int         div;
    logic       par_bit;
    int         len;
  } vec_t;

  vec_t vecs[6];

  uart_tx_engine dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .i_rempty     (i_rempty),
    .i_rdata      (i_rdata),
    .o_rinc       (o_rinc),
    .i_baud_div   (i_baud_div),
    .i_tx_en      (i_tx_en),
    .i_parity_en  (i_parity_en),
    .i_parity_odd (i_parity_odd),
    .i_two_stop   (i_two_stop),
    .o_txd        (o_txd),
    .o_tx_busy    (o_tx_busy),
    .o_tx_done    (o_tx_done)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic fifo_update();
    i_rempty = (fifo_q.size() == 0);
    i_rdata  = i_rempty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_update();
  endtask

  // FIFO read side: rinc is sampled late in the low phase and the pop lands just after the edge.
  initial begin
    logic take;
    forever begin
      @(negedge rclk);
      #3;
      take = o_rinc;
      @(posedge rclk);
      #1;
      if (take && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pop_count++;
      end
      fifo_update();
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_frame(input string nm, input int div, input logic pe, input logic par_bit,
                             input logic two, input int exp_len, input int drop_at, output logic b2b);
    logic [7:0] b;
    logic       exp_bit;
    logic       rinc1;
    int         t, p, nbits, k, done_at, bad_at, busy_bad;
    b2b = 1'b0;
    t = 0;
    #1;
    while (!o_rinc && t < 300) begin
      @(negedge rclk);
      #1;
      t++;
    end
    check({nm, " pop"}, 32'(o_rinc), 32'd1);
    if (!o_rinc) return;
    b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    p = div + 1;
    nbits = 10 + int'(pe) + int'(two);
    done_at = 0;
    bad_at = 0;
    busy_bad = 0;
    rinc1 = 1'b0;
    @(posedge rclk);
    for (int i = 1; i <= nbits * p; i++) begin
      @(negedge rclk);
      #1;
      if (i == drop_at) begin
        i_tx_en     = 1'b0;
        i_baud_div  = 16'd5;
        i_parity_en = 1'b1;
        i_two_stop  = 1'b1;
      end
      k = (i - 1) / p;
      if (k == 0)            exp_bit = 1'b0;
      else if (k <= 8)       exp_bit = b[k-1];
      else if (pe && k == 9) exp_bit = par_bit;
      else                   exp_bit = 1'b1;
      if (o_txd !== exp_bit && bad_at == 0) bad_at = i;
      if (o_tx_done === 1'b1 && done_at == 0) done_at = i;
      if (o_tx_busy !== 1'b1) busy_bad++;
      if (i == 1) rinc1 = o_rinc;
      if (i == nbits * p) b2b = o_rinc;
    end
    check({nm, " txd first bad cycle"}, 32'(bad_at), 32'd0);
    check({nm, " tx_done cycle"}, 32'(done_at), 32'(exp_len));
    check({nm, " busy low cycles"}, 32'(busy_bad), 32'd0);
    check({nm, " rinc single"}, 32'(rinc1), 32'd0);
  endtask

  task automatic check_idle(input string nm);
    @(negedge rclk);
    #1;
    check({nm, " idle busy"}, 32'(o_tx_busy), 32'd0);
    check({nm, " idle txd"}, 32'(o_txd), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b2b;
    int   pops0, t, bad;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 3, 1'b0, 40};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1, 1'b1, 22};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1, 1'b0, 22};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 2, 1'b1, 33};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b1, 0, 1'b0, 11};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 0, 1'b0, 12};

    checks = 0;
    failures = 0;
    pop_count = 0;
    rrst_n = 1'b0;
    i_tx_en = 1'b1;
    fifo_update();

    // Reset held with a byte waiting: nothing may be popped.
    @(negedge rclk);
    i_baud_div   = 16'(vecs[0].div);
    i_parity_en  = vecs[0].pe;
    i_parity_odd = vecs[0].odd;
    i_two_stop   = vecs[0].two;
    push_byte(vecs[0].data);
    repeat (3) @(negedge rclk);
    #1;
    check("reset rinc", 32'(o_rinc), 32'd0);
    check("reset txd", 32'(o_txd), 32'd1);
    check("reset busy", 32'(o_tx_busy), 32'd0);
    check("reset done", 32'(o_tx_done), 32'd0);
    @(negedge rclk);
    rrst_n = 1'b1;
    #1;
    check("first cycle pop", 32'(o_rinc), 32'd1);

    for (int v = 0; v < 6; v++) begin
      if (v != 0) begin
        i_baud_div   = 16'(vecs[v].div);
        i_parity_en  = vecs[v].pe;
        i_parity_odd = vecs[v].odd;
        i_two_stop   = vecs[v].two;
        push_byte(vecs[v].data);
      end
      check_frame($sformatf("vec%0d", v), vecs[v].div, vecs[v].pe, vecs[v].par_bit,
                  vecs[v].two, vecs[v].len, 0, b2b);
      check($sformatf("vec%0d no b2b", v), 32'(b2b), 32'd0);
      check_idle($sformatf("vec%0d", v));
    end
    check("pops after table", 32'(pop_count), 32'd6);

    // Back-to-back frames, second pop coincides with tx_done.
    i_baud_div = 16'd0; i_parity_en = 1'b0; i_parity_odd = 1'b0; i_two_stop = 1'b1;
    pops0 = pop_count;
    push_byte(8'h55);
    push_byte(8'h0F);
    check_frame("b2b0", 0, 1'b0, 1'b0, 1'b1, 11, 0, b2b);
    check("b2b second rinc at done", 32'(b2b), 32'd1);
    check_frame("b2b1", 0, 1'b0, 1'b0, 1'b1, 11, 0, b2b);
    check("b2b tail", 32'(b2b), 32'd0);
    check_idle("b2b");
    check("b2b pops", 32'(pop_count - pops0), 32'd2);

    // tx_en dropped and config changed mid-DATA: frame 1 finishes unchanged, no more pops.
    i_baud_div = 16'd1; i_parity_en = 1'b0; i_two_stop = 1'b0;
    pops0 = pop_count;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    check_frame("ten", 1, 1'b0, 1'b0, 1'b0, 20, 6, b2b);
    check("ten no b2b", 32'(b2b), 32'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge rclk);
      #1;
      if (o_txd !== 1'b1 || o_tx_busy !== 1'b0 || o_rinc !== 1'b0) bad++;
    end
    check("ten idle bad cycles", 32'(bad), 32'd0);
    check("ten pops", 32'(pop_count - pops0), 32'd1);

    // Async reset in the middle of DATA aborts the frame.
    i_baud_div = 16'd1; i_parity_en = 1'b0; i_two_stop = 1'b0;
    i_tx_en = 1'b1;
    t = 0;
    #1;
    while (!o_rinc && t < 50) begin
      @(negedge rclk);
      #1;
      t++;
    end
    check("abort pop", 32'(o_rinc), 32'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (8) @(negedge rclk);
    #1;
    check("abort in data busy", 32'(o_tx_busy), 32'd1);
    #1;
    rrst_n = 1'b0;
    #1;
    check("abort txd", 32'(o_txd), 32'd1);
    check("abort busy", 32'(o_tx_busy), 32'd0);
    check("abort rinc", 32'(o_rinc), 32'd0);
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
    check_frame("after abort", 1, 1'b0, 1'b0, 1'b0, 20, 0, b2b);
    check_idle("after abort");
    check("total pops", 32'(pop_count), 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Read-domain consumer of the UART TX async FIFO. It sits directly downstream of the FIFO read-pointer/empty logic and the FIFO memory. When the FIFO is non-empty, it pops one byte via rinc and serializes it on txd as an 8-bit UART frame: start bit, data LSB first, optional parity, and 1 or 2 stop bits. The bit rate is set by a programmable divider.

Parameters:
DATA_W, 8, data bits per frame (also the FIFO word width).
DIV_W, 16, width of the baud divider.

Ports:
rclk  in  1  read-domain clock.
rrst_n  in  1  reset, asynchronous, active-low.
rempty  in  1  registered FIFO empty flag.
rdata  in  DATA_W  FIFO memory read data at the current raddr; valid whenever rempty=0.
rinc  out  1  pop strobe to the FIFO read pointer; one cycle per byte.
baud_div  in  DIV_W  bit period = baud_div+1 rclk cycles.
tx_en  in  1  enables starting new frames.
parity_en  in  1  inserts a parity bit.
parity_odd  in  1  1 = odd parity, 0 = even parity.
two_stop  in  1  1 = two stop bits.
txd  out  1  serial output, idle high, registered.
tx_busy  out  1  high while a frame is in progress.
tx_done  out  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (async, rrst_n=0): state IDLE, txd=1, rinc=0, tx_busy=0, tx_done=0, bit counter and baud counter 0. Reset mid-frame aborts the frame immediately, and txd returns to 1.
- States:
  - IDLE -> START -> DATA -> [PARITY if parity_en] -> STOP -> IDLE or START.
- rinc is combinational from registered state: rinc = tx_en & ~rempty & (state==IDLE | last cycle of final stop bit).
- Pop edge (rinc=1):
  - Capture rdata into the shift register.
  - Latch baud_div, parity_en, parity_odd and two_stop for the whole frame.
  - Next state START; txd<=0 on the same edge.
- Never pops while rempty=1. rinc is high for exactly one cycle per frame. rempty updates the cycle after the pop, and the FSM is then in START, so a byte is never double-popped.
- Baud counter:
  - Loads the latched divider at each bit start and decrements each cycle.
  - The bit ends when the counter is 0.
  - Every bit lasts exactly div+1 cycles; div=0 gives 1 cycle per bit.
- DATA: 8 bits, LSB first. The shift register shifts right at each bit end. The 3-bit bit counter ends the state after bit 7.
- PARITY: bit = XOR of the captured byte XOR parity_odd.
- STOP: txd=1 for 1 or 2 bit periods.
- Last cycle of the final stop bit:
  - tx_done=1.
  - If a pop is possible (rinc=1), go directly to START with no idle gap (back-to-back frames).
  - Otherwise go to IDLE.
- Frame length = (1+8+parity_en+1+two_stop)*(div+1) cycles, measured from the cycle after the pop.
- tx_busy=1 in every state except IDLE.
- tx_en deasserted mid-frame: the current frame completes and no new pop occurs.
- Config inputs changed mid-frame: no effect until the next pop.
- txd is driven only from flops, so it is glitch-free.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding (IDLE, START, DATA, PARITY, STOP).
  - DATA_W default.
  - Stop/parity config constants, shared with uart_rx and the APB register block.
- One sub-module: uart_bit_timer.
  - Loadable down-counter of DIV_W bits.
  - Inputs: load, load value.
  - Output: bit_end pulse.

Test Plan:
1. Reset with rempty=0 held -> rinc=0, txd=1, tx_busy=0 while reset is asserted. The first pop happens in the first cycle after release, provided tx_en=1.
2. Single byte 0xA5, div=3, no parity, 1 stop:
   - rinc=1 for exactly 1 cycle.
   - txd sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
   - tx_done pulses at cycle 40 after the pop.
   - FSM returns to IDLE with tx_busy=0.
3. Parity: 0x07 with even parity -> parity bit 1. 0x07 with odd parity -> 0. 0x00 with odd parity -> 1. Each frame is 11 bit periods.
4. Back-to-back: FIFO holds 0x55 and 0x0F, div=0, two_stop=1 -> second rinc coincides with tx_done. The second start bit follows the second stop bit immediately, with no idle cycle. Exactly 2 pops in total.
5. tx_en dropped during DATA of frame 1 with 3 bytes queued -> frame 1 completes, then no further rinc, and txd stays 1.
6. Async reset asserted mid-DATA -> txd=1 and tx_busy=0 immediately. After release, the FIFO byte at the current raddr is sent as a fresh frame.
